add_sub_serial: RTL and testbench

Parametrised, multi-cycle two's-complement adder/subtractor that processes operands DIGIT bits per clock, LSB digit first. It is the sequential, width-generic successor to the team's 4-bit combinational add/sub unit. It adds a start/ready/done handshake, signed-overflow detection, an optional saturation mode and a zero flag. It sits between a register-file/operand source and any consumer that can tolerate WIDTH/DIGIT cycles of latency in exchange for a narrow adder.

---
 rtl/add_sub_serial_if.sv | 31 +++
 rtl/add_sub_serial.sv | 177 +++++++++++++++++
 tb/tb_add_sub_serial.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_sub_serial_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The master side (operand source) drives the request and operands;
// the slave side (the arithmetic unit) returns handshake status,
// the result and its flags.
interface add_sub_serial_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ctrl;
  logic             sat;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Op;
  logic             Cout;
  logic             Ovf;
  logic             Zero;

  modport master (
    output start, A, B, ctrl, sat,
    input  ready, done, Op, Cout, Ovf, Zero
  );

  modport slave (
    input  start, A, B, ctrl, sat,
    output ready, done, Op, Cout, Ovf, Zero
  );

endinterface

// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor.
// Operands are consumed DIGIT bits per clock, least significant digit
// first, so a WIDTH-bit operation takes WIDTH/DIGIT busy cycles through
// a DIGIT-bit adder. Subtraction is A + ~B + 1: B is inverted on accept
// and the carry register is preloaded with 1. The final digit also
// yields the signed-overflow flag, the optional saturated result and
// the zero flag. Results are only ever written on the completing edge,
// so the outputs hold the last finished operation while a new one runs.
module add_sub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  add_sub_serial_if.slave    bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reject geometries the digit slicing cannot handle.
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gBadParam
    $error("add_sub_serial: need WIDTH >= 2, 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q;
  state_e state_d;

  // Handshake / control
  logic             ready;
  logic             accept;
  logic             lastDigit;

  // Operand shift registers; the low DIGIT bits are always the digit
  // being processed, so on the last digit their top bits are the MSBs.
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bmShift_q;
  logic             carry_q;
  logic             sat_q;
  logic [CW-1:0]    digCnt_q;

  // Result registers, visible on the bus
  logic [WIDTH-1:0] op_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             done_q;

  // Per-digit arithmetic
  logic [DIGIT:0]   digSum;
  logic [WIDTH-1:0] fullSum;
  logic             aMsb;
  logic             bmMsb;
  logic             sMsb;
  logic             ovfNow;
  logic [WIDTH-1:0] satMin;
  logic [WIDTH-1:0] satMax;
  logic [WIDTH-1:0] finalOp;

  assign accept    = bus.start & ready;
  assign lastDigit = (digCnt_q == CW'(NDIG - 1));

  assign digSum = {1'b0, aShift_q[DIGIT-1:0]}
                + {1'b0, bmShift_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};

  // With more than one digit the already-computed low digits live in a
  // partial register that shifts right as each new digit enters at the
  // top; after the last digit the concatenation is the complete sum.
  if (NDIG == 1) begin : gSingle
    assign fullSum = digSum[DIGIT-1:0];
  end else begin : gMulti
    logic [WIDTH-DIGIT-1:0] partial_q;

    // Collect finished digits of the sum while the operation runs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        partial_q <= '0;
      end else if (state_q == BUSY) begin
        partial_q <= fullSum[WIDTH-1:DIGIT];
      end
    end

    assign fullSum = {digSum[DIGIT-1:0], partial_q};
  end

  // Overflow: operands of equal sign producing a sum of the other sign.
  assign aMsb    = aShift_q[DIGIT-1];
  assign bmMsb   = bmShift_q[DIGIT-1];
  assign sMsb    = digSum[DIGIT-1];
  assign ovfNow  = (aMsb == bmMsb) && (sMsb != aMsb);

  assign satMin  = {1'b1, {(WIDTH-1){1'b0}}};
  assign satMax  = ~satMin;

  // A negative A can only overflow downwards, a non-negative A upwards.
  assign finalOp = (sat_q && ovfNow) ? (aMsb ? satMin : satMax) : fullSum;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave IDLE on an accepted request, return after the last digit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = BUSY;
      BUSY:    if (lastDigit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: ready only while idle (includes the done cycle).
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      BUSY:    ready = 1'b0;
      default: ready = 1'b0;
    endcase
  end

  // Operand capture, digit stepping and result commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aShift_q  <= '0;
      bmShift_q <= '0;
      carry_q   <= 1'b0;
      sat_q     <= 1'b0;
      digCnt_q  <= '0;
      op_q      <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        aShift_q  <= bus.A;
        bmShift_q <= bus.B ^ {WIDTH{bus.ctrl}};
        carry_q   <= bus.ctrl;
        sat_q     <= bus.sat;
        digCnt_q  <= '0;
      end else if (state_q == BUSY) begin
        aShift_q  <= aShift_q >> DIGIT;
        bmShift_q <= bmShift_q >> DIGIT;
        carry_q   <= digSum[DIGIT];
        digCnt_q  <= digCnt_q + CW'(1);
        if (lastDigit) begin
          op_q   <= finalOp;
          cout_q <= digSum[DIGIT];
          ovf_q  <= ovfNow;
          zero_q <= (finalOp == '0);
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ready = ready;
  assign bus.done  = done_q;
  assign bus.Op    = op_q;
  assign bus.Cout  = cout_q;
  assign bus.Ovf   = ovf_q;
  assign bus.Zero  = zero_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: four instances with different WIDTH/DIGIT
// geometries, each shadowed by an arithmetic reference model that knows
// only the operation's latency and its mathematical result.
module tb_add_sub_serial;

  typedef struct packed {
    logic [15:0] op;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  logic [3:0]       startV = '0;
  logic [3:0]       ctrlV  = '0;
  logic [3:0]       satV   = '0;
  logic [3:0][15:0] aV     = '0;
  logic [3:0][15:0] bV     = '0;

  logic [3:0]       readyV;
  logic [3:0]       doneV;
  logic [3:0]       coutV;
  logic [3:0]       ovfV;
  logic [3:0]       zeroV;
  logic [3:0][15:0] opV;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input int cfg, input string name,
                             input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL cfg%0d %s: got %h, expected %h (cycle %0d)",
               cfg, name, actual, expected, cycle);
    end
  endtask

  // Result from plain signed/unsigned integer arithmetic.
  function automatic res_t refModel(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic ctrl, input logic sat);
    res_t   r;
    longint one, mask, ua, ub, sa, sb, t, maxV, minV;
    one  = 1;
    mask = (one << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    sb   = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    maxV = (one << (w - 1)) - 1;
    minV = -(one << (w - 1));
    t    = ctrl ? sa - sb : sa + sb;
    r.ovf  = (t > maxV) || (t < minV);
    r.cout = ctrl ? (ua >= ub) : ((ua + ub) > mask);
    if (sat && r.ovf) t = (t > maxV) ? maxV : minV;
    r.op   = 16'(t & mask);
    r.zero = (r.op == 16'd0);
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gCfg
    localparam int W = (g == 3) ? 16 : 8;
    localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 8 : 4;
    localparam int N = W / D;

    add_sub_serial_if #(.WIDTH(W)) bus ();

    add_sub_serial #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.start = startV[g];
    assign bus.A     = aV[g][W-1:0];
    assign bus.B     = bV[g][W-1:0];
    assign bus.ctrl  = ctrlV[g];
    assign bus.sat   = satV[g];
    assign readyV[g] = bus.ready;
    assign doneV[g]  = bus.done;
    assign coutV[g]  = bus.Cout;
    assign ovfV[g]   = bus.Ovf;
    assign zeroV[g]  = bus.Zero;
    assign opV[g]    = 16'(bus.Op);

    int   rem         = 0;
    int   acceptCycle = 0;
    int   mOps        = 0;
    res_t pend        = '0;
    res_t expR        = '0;
    logic expDone     = 1'b0;

    // Reference: an accepted op publishes its result N cycles later.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rem     <= 0;
        pend    <= '0;
        expR    <= '0;
        expDone <= 1'b0;
      end else begin
        expDone <= (rem == 1);
        if (rem == 1) begin
          expR <= pend;
          mOps <= mOps + 1;
        end
        if (rem > 0) begin
          rem <= rem - 1;
        end else if (startV[g]) begin
          rem         <= N;
          pend        <= refModel(W, aV[g], bV[g], ctrlV[g], satV[g]);
          acceptCycle <= cycle + 1;
        end
      end
    end

    // Compare every output against the reference on each falling edge.
    always @(negedge clk) begin
      checkOutput(g, "ready", 16'(readyV[g]), 16'(rem == 0));
      checkOutput(g, "done",  16'(doneV[g]),  16'(expDone));
      checkOutput(g, "Op",    opV[g],         expR.op);
      checkOutput(g, "Cout",  16'(coutV[g]),  16'(expR.cout));
      checkOutput(g, "Ovf",   16'(ovfV[g]),   16'(expR.ovf));
      checkOutput(g, "Zero",  16'(zeroV[g]),  16'(expR.zero));
      if (doneV[g] === 1'b1)
        checkOutput(g, "doneLatency", 16'(cycle - acceptCycle), 16'(N));
    end
  end

  // Present one request for exactly one edge (assumes the unit is ready).
  task automatic applyStimulus(input int cfg, input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic s);
    startV[cfg] = 1'b1;
    aV[cfg]     = a;
    bV[cfg]     = b;
    ctrlV[cfg]  = c;
    satV[cfg]   = s;
    @(posedge clk);
    #1;
    startV[cfg] = 1'b0;
  endtask

  task automatic waitDone(input int cfg, output int lat);
    lat = 0;
    while (doneV[cfg] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (doneV[cfg] !== 1'b1) checkOutput(cfg, "doneTimeout", 16'(0), 16'(1));
  endtask

  task automatic runOp(input int cfg, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input logic [15:0] eOp,
                       input logic eC, input logic eO, input logic eZ, input int eLat);
    int lat;
    applyStimulus(cfg, a, b, c, s);
    waitDone(cfg, lat);
    checkOutput(cfg, "latency", 16'(lat), 16'(eLat));
    checkOutput(cfg, "litOp",   opV[cfg], eOp);
    checkOutput(cfg, "litCout", 16'(coutV[cfg]), 16'(eC));
    checkOutput(cfg, "litOvf",  16'(ovfV[cfg]),  16'(eO));
    checkOutput(cfg, "litZero", 16'(zeroV[cfg]), 16'(eZ));
  endtask

  function automatic logic [15:0] pickOperand(input int w);
    logic [15:0] minV;
    minV = 16'(1) << (w - 1);
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return minV;
      3:       return minV - 16'd1;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic int widthOf(input int cfg);
    return (cfg == 3) ? 16 : 8;
  endfunction

  initial begin
    res_t r;
    int   lat;
    int   cnt;
    int   budget;
    logic allDone;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput(0, "rstOp",    opV[0],          16'h0000);
    checkOutput(0, "rstReady", 16'(readyV[0]),  16'(1));
    checkOutput(0, "rstDone",  16'(doneV[0]),   16'(0));

    r = refModel(8, 16'd100, 16'd50, 1'b0, 1'b1);
    checkOutput(0, "modelSatOp",  r.op, 16'h007F);
    checkOutput(0, "modelSatOvf", 16'(r.ovf), 16'(1));
    r = refModel(16, 16'h8000, 16'h0001, 1'b1, 1'b0);
    checkOutput(3, "modelSubOp",   r.op, 16'h7FFF);
    checkOutput(3, "modelSubCout", 16'(r.cout), 16'(1));
    r = refModel(8, 16'd5, 16'd7, 1'b1, 1'b0);
    checkOutput(0, "modelBorrow", {r.op[14:0], r.cout}, {15'h00FE, 1'b0});

    $display("[TB] directed operations on WIDTH=8 DIGIT=2");
    runOp(0, 16'd5,    16'd3,    1'b0, 1'b0, 16'h08, 1'b0, 1'b0, 1'b0, 4);
    runOp(0, 16'd5,    16'd7,    1'b1, 1'b0, 16'hFE, 1'b0, 1'b0, 1'b0, 4);
    runOp(0, 16'd7,    16'd5,    1'b1, 1'b0, 16'h02, 1'b1, 1'b0, 1'b0, 4);
    runOp(0, 16'd3,    16'd3,    1'b1, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 4);
    runOp(0, 16'd100,  16'd50,   1'b0, 1'b0, 16'h96, 1'b0, 1'b1, 1'b0, 4);
    runOp(0, 16'd100,  16'd50,   1'b0, 1'b1, 16'h7F, 1'b0, 1'b1, 1'b0, 4);
    runOp(0, 16'h80,   16'h01,   1'b1, 1'b1, 16'h80, 1'b1, 1'b1, 1'b0, 4);
    runOp(0, 16'hFE,   16'hFB,   1'b0, 1'b0, 16'hF9, 1'b1, 1'b0, 1'b0, 4);

    $display("[TB] back-to-back request in the done cycle");
    runOp(0, 16'd10, 16'd20, 1'b0, 1'b0, 16'd30, 1'b0, 1'b0, 1'b0, 4);
    applyStimulus(0, 16'h40, 16'h41, 1'b1, 1'b0);
    checkOutput(0, "heldOp", opV[0], 16'd30);
    waitDone(0, lat);
    checkOutput(0, "b2bLatency", 16'(lat), 16'(4));
    checkOutput(0, "b2bOp",      opV[0], 16'hFF);
    checkOutput(0, "b2bCout",    16'(coutV[0]), 16'(0));

    $display("[TB] start held high through the busy phase");
    @(posedge clk);
    #1;
    startV[0] = 1'b1;
    aV[0] = 16'hFF;
    bV[0] = 16'h02;
    ctrlV[0] = 1'b0;
    satV[0] = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    startV[0] = 1'b0;
    cnt = 0;
    repeat (12) begin
      if (doneV[0] === 1'b1) cnt++;
      @(posedge clk);
      #1;
    end
    checkOutput(0, "singleDone", 16'(cnt), 16'(1));
    checkOutput(0, "heldStartOp",   opV[0], 16'h01);
    checkOutput(0, "heldStartCout", 16'(coutV[0]), 16'(1));

    $display("[TB] reset in the middle of an operation");
    applyStimulus(0, 16'h11, 16'h22, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput(0, "midRstOp",    opV[0],         16'h00);
    checkOutput(0, "midRstCout",  16'(coutV[0]),  16'(0));
    checkOutput(0, "midRstReady", 16'(readyV[0]), 16'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      if (doneV[0] === 1'b1) cnt++;
      @(posedge clk);
      #1;
    end
    checkOutput(0, "abortedDone", 16'(cnt), 16'(0));
    runOp(0, 16'd9, 16'd4, 1'b1, 1'b0, 16'h05, 1'b1, 1'b0, 1'b0, 4);

    $display("[TB] random sweep on all geometries");
    budget  = 0;
    allDone = 1'b0;
    while (!allDone && budget < 30000) begin
      for (int i = 0; i < 4; i++) begin
        startV[i] = ($urandom_range(0, 3) != 0);
        aV[i]     = pickOperand(widthOf(i));
        bV[i]     = ($urandom_range(0, 7) == 0) ? aV[i] : pickOperand(widthOf(i));
        ctrlV[i]  = 1'($urandom_range(0, 1));
        satV[i]   = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      budget++;
      allDone = (gCfg[0].mOps >= 1000) && (gCfg[1].mOps >= 1000) &&
                (gCfg[2].mOps >= 1000) && (gCfg[3].mOps >= 1000);
    end
    startV = '0;
    checkOutput(0, "sweepComplete", 16'(allDone), 16'(1));
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
